// File: rtl/bp_nonsynth_dma_mem.sv
// Single-channel DRAM model behind one bsg_cache_dma channel: one outstanding
// read or write burst at a time, with reads returned after a fixed latency.
module bp_nonsynth_dma_mem #(
    parameter int addr_width_p   = 28,
    parameter int data_width_p   = 64,
    parameter int burst_len_p    = 8,
    parameter int mem_els_p      = 4096,
    parameter int read_latency_p = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic [addr_width_p:0]   dma_pkt_i,
    input  logic                    dma_pkt_v_i,
    output logic                    dma_pkt_yumi_o,

    output logic [data_width_p-1:0] dma_data_o,
    output logic                    dma_data_v_o,
    input  logic                    dma_data_ready_and_i,

    input  logic [data_width_p-1:0] dma_data_i,
    input  logic                    dma_data_v_i,
    output logic                    dma_data_yumi_o
);

    localparam int lg_bytes_lp = (data_width_p / 8 > 1) ? $clog2(data_width_p / 8) : 0;
    localparam int lg_els_lp   = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
    localparam int beat_w_lp   = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
    localparam int lat_w_lp    = (read_latency_p > 0) ? $clog2(read_latency_p + 1) : 1;
    localparam int ext_w_lp    = (addr_width_p > lg_els_lp) ? addr_width_p : lg_els_lp;

    if (data_width_p % 8 != 0) begin : g_bad_data_width
        $error("bp_nonsynth_dma_mem: data_width_p must be a multiple of 8");
    end
    if (burst_len_p < 1) begin : g_bad_burst_len
        $error("bp_nonsynth_dma_mem: burst_len_p must be at least 1");
    end
    if ((mem_els_p < 1) || ((mem_els_p & (mem_els_p - 1)) != 0)) begin : g_bad_mem_els
        $error("bp_nonsynth_dma_mem: mem_els_p must be a power of two");
    end

    typedef enum logic [1:0] {
        e_idle,
        e_rd_wait,
        e_rd_send,
        e_wr_recv
    } state_e;

    state_e                  r_state;
    logic [lg_els_lp-1:0]    r_base;
    logic [beat_w_lp-1:0]    r_beat;
    logic [lat_w_lp-1:0]     r_lat;
    logic [data_width_p-1:0] r_mem [mem_els_p] = '{default: '0};

    logic                    w_pkt_wnr;
    logic [ext_w_lp-1:0]     w_word_addr;
    logic [lg_els_lp-1:0]    w_pkt_idx;
    logic [lg_els_lp-1:0]    w_idx;
    logic                    w_last_beat;
    logic                    w_pkt_yumi;
    logic                    w_rd_v;
    logic                    w_rd_xfer;
    logic                    w_wr_yumi;

    // Byte-offset bits within a beat are dropped; the word index wraps at the array top.
    assign w_pkt_wnr   = dma_pkt_i[addr_width_p];
    assign w_word_addr = ext_w_lp'(dma_pkt_i[addr_width_p-1:0]) >> lg_bytes_lp;
    assign w_pkt_idx   = lg_els_lp'(w_word_addr);
    assign w_idx       = (mem_els_p == 1) ? '0 : (r_base + lg_els_lp'(r_beat));
    assign w_last_beat = (r_beat == beat_w_lp'(burst_len_p - 1));

    // Handshakes are gated by reset so every output is quiet while reset is held.
    assign w_pkt_yumi = reset_n_i & (r_state == e_idle) & dma_pkt_v_i;
    assign w_rd_v     = reset_n_i & (r_state == e_rd_send);
    assign w_rd_xfer  = w_rd_v & dma_data_ready_and_i;
    assign w_wr_yumi  = reset_n_i & (r_state == e_wr_recv) & dma_data_v_i;

    assign dma_pkt_yumi_o  = w_pkt_yumi;
    assign dma_data_v_o    = w_rd_v;
    assign dma_data_o      = w_rd_v ? r_mem[w_idx] : '0;
    assign dma_data_yumi_o = w_wr_yumi;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= e_idle;
            r_beat  <= '0;
            r_lat   <= '0;
        end else begin
            case (r_state)
                e_idle: begin
                    if (w_pkt_yumi) begin
                        r_beat <= '0;
                        if (w_pkt_wnr) begin
                            r_state <= e_wr_recv;
                        end else if (read_latency_p > 0) begin
                            r_lat   <= lat_w_lp'(read_latency_p);
                            r_state <= e_rd_wait;
                        end else begin
                            r_state <= e_rd_send;
                        end
                    end
                end
                e_rd_wait: begin
                    r_lat <= r_lat - lat_w_lp'(1);
                    if (r_lat <= lat_w_lp'(1)) begin
                        r_state <= e_rd_send;
                    end
                end
                e_rd_send: begin
                    if (w_rd_xfer) begin
                        r_beat <= r_beat + beat_w_lp'(1);
                        if (w_last_beat) begin
                            r_state <= e_idle;
                        end
                    end
                end
                e_wr_recv: begin
                    if (w_wr_yumi) begin
                        r_beat <= r_beat + beat_w_lp'(1);
                        if (w_last_beat) begin
                            r_state <= e_idle;
                        end
                    end
                end
                default: r_state <= e_idle;
            endcase
        end
    end

    // Base index is only meaningful after an accept, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (w_pkt_yumi) begin
            r_base <= w_pkt_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_yumi) begin
            r_mem[w_idx] <= dma_data_i;
        end
    end

endmodule

// File: tb/tb_bp_nonsynth_dma_mem.sv
// Directed bench for bp_nonsynth_dma_mem with a 16-word array so index wrap is reachable.
module tb_bp_nonsynth_dma_mem;

    localparam int AW = 28;
    localparam int DW = 64;
    localparam int BL = 8;
    localparam int LAT = 4;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic [AW:0]   dma_pkt_i;
    logic          dma_pkt_v_i;
    logic          dma_pkt_yumi_o;
    logic [DW-1:0] dma_data_o;
    logic          dma_data_v_o;
    logic          dma_data_ready_and_i;
    logic [DW-1:0] dma_data_i;
    logic          dma_data_v_i;
    logic          dma_data_yumi_o;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [63:0]   exp_q [BL];

    bp_nonsynth_dma_mem #(
        .addr_width_p  (AW),
        .data_width_p  (DW),
        .burst_len_p   (BL),
        .mem_els_p     (16),
        .read_latency_p(LAT)
    ) dut (
        .clk_i               (clk_i),
        .reset_n_i           (reset_n_i),
        .dma_pkt_i           (dma_pkt_i),
        .dma_pkt_v_i         (dma_pkt_v_i),
        .dma_pkt_yumi_o      (dma_pkt_yumi_o),
        .dma_data_o          (dma_data_o),
        .dma_data_v_o        (dma_data_v_o),
        .dma_data_ready_and_i(dma_data_ready_and_i),
        .dma_data_i          (dma_data_i),
        .dma_data_v_i        (dma_data_v_i),
        .dma_data_yumi_o     (dma_data_yumi_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_pkt(input logic wnr, input logic [AW-1:0] addr);
        dma_pkt_v_i = 1'b1;
        dma_pkt_i   = {wnr, addr};
        #1;
        check("pkt_yumi", {63'd0, dma_pkt_yumi_o}, 64'd1);
        step();
        dma_pkt_v_i = 1'b0;
    endtask

    // Beats are start, start+1, ...; vpat bit c is the data-valid for cycle c.
    task automatic write_beats(input logic [63:0] start, input logic [31:0] vpat);
        int k;
        k = 0;
        for (int c = 0; c < 32 && k < BL; c++) begin
            dma_data_v_i = vpat[c];
            dma_data_i   = start + 64'(k);
            #1;
            check("wr_yumi", {63'd0, dma_data_yumi_o}, {63'd0, vpat[c]});
            check("wr_pkt_yumi", {63'd0, dma_pkt_yumi_o}, 64'd0);
            step();
            if (vpat[c]) k++;
        end
        dma_data_v_i = 1'b1;
        dma_data_i   = 64'hDEAD;
        #1;
        check("wr_extra_yumi", {63'd0, dma_data_yumi_o}, 64'd0);
        dma_data_v_i = 1'b0;
    endtask

    // Called right after the accept edge; rpat bit c is ready for send cycle c.
    task automatic read_beats(input logic [31:0] rpat, input int nbeats);
        int k;
        for (int i = 0; i < LAT; i++) begin
            dma_data_ready_and_i = 1'b1;
            #1;
            check("rd_wait_v", {63'd0, dma_data_v_o}, 64'd0);
            check("rd_wait_data", dma_data_o, 64'd0);
            step();
        end
        k = 0;
        for (int c = 0; c < 32 && k < nbeats; c++) begin
            dma_data_ready_and_i = rpat[c];
            #1;
            check("rd_v", {63'd0, dma_data_v_o}, 64'd1);
            check("rd_data", dma_data_o, exp_q[k]);
            step();
            if (rpat[c]) k++;
        end
        if (nbeats == BL) begin
            dma_data_ready_and_i = 1'b0;
            #1;
            check("rd_done_v", {63'd0, dma_data_v_o}, 64'd0);
        end
    endtask

    initial begin
        logic [31:0] gap_pat;
        for (int c = 0; c < 32; c++) begin
            gap_pat[c] = (c % 5 == 0) || (c % 5 == 2) || (c % 5 == 3);
        end

        reset_n_i            = 1'b0;
        dma_pkt_v_i          = 1'b1;
        dma_pkt_i            = {1'b1, 28'h100};
        dma_data_v_i         = 1'b1;
        dma_data_i           = 64'h55;
        dma_data_ready_and_i = 1'b1;

        // Reset held with a packet pending: nothing is accepted or driven.
        repeat (3) step();
        check("rst_pkt_yumi", {63'd0, dma_pkt_yumi_o}, 64'd0);
        check("rst_data_v", {63'd0, dma_data_v_o}, 64'd0);
        check("rst_data_yumi", {63'd0, dma_data_yumi_o}, 64'd0);
        check("rst_data_o", dma_data_o, 64'd0);
        reset_n_i = 1'b1;
        #1;
        check("rel_pkt_yumi", {63'd0, dma_pkt_yumi_o}, 64'd1);
        check("rel_data_yumi", {63'd0, dma_data_yumi_o}, 64'd0);
        step();
        dma_pkt_v_i  = 1'b0;
        dma_data_v_i = 1'b0;

        // Write 0x11..0x18 at 0x100 (word 32 -> index 0), read back.
        write_beats(64'h11, 32'hFFFF_FFFF);
        exp_q = '{64'h11, 64'h12, 64'h13, 64'h14, 64'h15, 64'h16, 64'h17, 64'h18};
        send_pkt(1'b0, 28'h100);
        read_beats(32'hFFFF_FFFF, BL);

        // Backpressure: ready 1,0,0,1 repeating.
        send_pkt(1'b0, 28'h100);
        read_beats(32'h9999_9999, BL);

        // Wrap: write at index 12 (0x60) covers 12..15 then 0..3.
        send_pkt(1'b1, 28'h60);
        write_beats(64'hA1, 32'hFFFF_FFFF);
        exp_q = '{64'hA5, 64'hA6, 64'hA7, 64'hA8, 64'h15, 64'h16, 64'h17, 64'h18};
        send_pkt(1'b0, 28'h0);
        read_beats(32'hFFFF_FFFF, BL);
        exp_q = '{64'hA1, 64'hA2, 64'hA3, 64'hA4, 64'hA5, 64'hA6, 64'hA7, 64'hA8};
        send_pkt(1'b0, 28'h67);
        read_beats(32'hFFFF_FFFF, BL);

        // Gapped write at index 4 while the next packet is already pending.
        send_pkt(1'b1, 28'h20);
        dma_pkt_v_i = 1'b1;
        dma_pkt_i   = {1'b0, 28'h20};
        write_beats(64'hC1, gap_pat);
        exp_q = '{64'hC1, 64'hC2, 64'hC3, 64'hC4, 64'hC5, 64'hC6, 64'hC7, 64'hC8};
        send_pkt(1'b0, 28'h20);
        read_beats(32'hFFFF_FFFF, BL);
        exp_q = '{64'hA1, 64'hA2, 64'hA3, 64'hA4, 64'hA5, 64'hA6, 64'hA7, 64'hA8};
        send_pkt(1'b0, 28'h60);
        read_beats(32'hFFFF_FFFF, BL);

        // Reset after three read beats, then a full read of the same block.
        exp_q = '{64'hA5, 64'hA6, 64'hA7, 64'hA8, 64'hC1, 64'hC2, 64'hC3, 64'hC4};
        send_pkt(1'b0, 28'h0);
        read_beats(32'hFFFF_FFFF, 3);
        reset_n_i = 1'b0;
        #1;
        check("midrst_data_v", {63'd0, dma_data_v_o}, 64'd0);
        check("midrst_data_o", dma_data_o, 64'd0);
        step();
        reset_n_i            = 1'b1;
        dma_data_ready_and_i = 1'b0;
        #1;
        check("postrst_data_v", {63'd0, dma_data_v_o}, 64'd0);
        send_pkt(1'b0, 28'h0);
        read_beats(32'hFFFF_FFFF, BL);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete by %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
